// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory bus; data wins by default.
// Optional macro MEM_ARBITER_FAIRNESS_EN: fetch wins after STARVE_LIMIT data grants in a row.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be in 2..255");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD} state_t;

    state_t            state_q, state_d;
    logic [7:0]        wait_q, wait_d;
    logic              pick_if;
    logic              if_gnt_d, if_rvalid_d, d_gnt_d, d_rvalid_d, mem_en_d, mem_we_d, err_d;
    logic [DATA_W-1:0] if_rdata_d, d_rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;

`ifdef MEM_ARBITER_FAIRNESS_EN
    logic [3:0] streak_q, streak_d;

    assign pick_if = if_req && (!d_req || streak_q == 4'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign pick_if = if_req && !d_req;
`endif

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        mem_en_d    = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        err_d       = 1'b0;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
`ifdef MEM_ARBITER_FAIRNESS_EN
        streak_d    = streak_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (pick_if) begin
                    if_gnt_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    wait_d      = '0;
                    state_d     = StBusyIf;
`ifdef MEM_ARBITER_FAIRNESS_EN
                    streak_d    = '0;
`endif
                end else if (d_req) begin
                    d_gnt_d     = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    wait_d      = '0;
                    state_d     = StBusyD;
`ifdef MEM_ARBITER_FAIRNESS_EN
                    // Only data grants that made a waiting fetch wait extend the streak.
                    streak_d    = if_req ? streak_q + 4'd1 : '0;
`endif
                end else begin
`ifdef MEM_ARBITER_FAIRNESS_EN
                    streak_d    = '0;
`endif
                end
            end
            StBusyIf, StBusyD: begin
                if (mem_ready) begin
                    state_d = StIdle;
                    if (state_q == StBusyIf) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_we ? '0 : mem_rdata;
                    end
                end else if (wait_q == 8'(TIMEOUT)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    if (state_q == StBusyIf) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = '0;
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = '0;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            if_gnt    <= if_gnt_d;
            if_rvalid <= if_rvalid_d;
            if_rdata  <= if_rdata_d;
            d_gnt     <= d_gnt_d;
            d_rvalid  <= d_rvalid_d;
            d_rdata   <= d_rdata_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected grants and responses, with a
// background memory responder whose mem_ready delay is set per step.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, mem_ready, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

`ifdef MEM_ARBITER_FAIRNESS_EN
    localparam bit Fair = 1'b1;
`else
    localparam bit Fair = 1'b0;
`endif

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_if;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } gnt_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    gnt_t gnt_q[$];
    rsp_t if_rsp_q[$];
    rsp_t d_rsp_q[$];
    gnt_t mon_g;
    rsp_t mon_r;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_gnt = -100;
    int resp_delay = 0;
    int resp_cnt = 0;
    logic [31:0] resp_data = '0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h40) ? 32'h1234 : ((a * 32'd7) ^ 32'hC0DE_0000);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, err}), 0);
        check({tag, "_if_rdata"}, 64'(if_rdata), 0);
        check({tag, "_d_rdata"}, 64'(d_rdata), 0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: mem_ready follows mem_en by resp_delay cycles (0 = never).
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            step();
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = resp_data;
                end
            end else if (mem_en && resp_delay > 0) begin
                resp_cnt  = resp_delay;
                resp_data = mem_model(mem_addr);
            end
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        check("mem_en_with_gnt", 64'(mem_en), 64'(if_gnt | d_gnt));
        check("err_with_rvalid", 64'(err & ~(if_rvalid | d_rvalid)), 0);
        if (if_gnt || d_gnt) begin
            check("gnt_onehot", 64'(if_gnt & d_gnt), 0);
            check("gnt_spacing_ge3", 64'(cyc - last_gnt >= 3), 1);
            last_gnt = cyc;
            check("gnt_expected", 64'(gnt_q.size() > 0), 1);
            if (gnt_q.size() > 0) begin
                mon_g = gnt_q.pop_front();
                check("gnt_kind_is_if", 64'(if_gnt), 64'(mon_g.is_if));
                check("gnt_mem_addr", 64'(mem_addr), 64'(mon_g.addr));
                check("gnt_mem_we", 64'(mem_we), 64'(mon_g.we));
                check("gnt_mem_wdata", 64'(mem_wdata), 64'(mon_g.wdata));
            end
        end
        if (d_rvalid) begin
            check("d_rsp_expected", 64'(d_rsp_q.size() > 0), 1);
            if (d_rsp_q.size() > 0) begin
                mon_r = d_rsp_q.pop_front();
                check("d_rdata", 64'(d_rdata), 64'(mon_r.rdata));
                check("d_err", 64'(err), 64'(mon_r.err));
            end
        end
        if (if_rvalid) begin
            check("if_rsp_expected", 64'(if_rsp_q.size() > 0), 1);
            if (if_rsp_q.size() > 0) begin
                mon_r = if_rsp_q.pop_front();
                check("if_rdata", 64'(if_rdata), 64'(mon_r.rdata));
                check("if_err", 64'(err), 64'(mon_r.err));
            end
        end
    end

    task automatic wait_gnt(input bit is_if, output int lat);
        bit seen = 1'b0;
        lat = 0;
        while (!seen && lat < 50) begin
            step();
            lat++;
            seen = is_if ? if_gnt : d_gnt;
        end
        check(is_if ? "if_gnt_seen" : "d_gnt_seen", 64'(seen), 1);
    endtask

    task automatic wait_rvalid(input bit is_if, input logic [31:0] addr, output int lat);
        bit seen = 1'b0;
        lat = 0;
        while (!seen && lat < 50) begin
            step();
            lat++;
            seen = is_if ? if_rvalid : d_rvalid;
            if (!seen) check("mem_addr_held", 64'(mem_addr), 64'(addr));
        end
        check(is_if ? "if_rvalid_seen" : "d_rvalid_seen", 64'(seen), 1);
    endtask

    task automatic run_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat);
        int lat;
        resp_delay = delay;
        gnt_q.push_back('{1'b0, addr, we, wdata});
        d_rsp_q.push_back('{exp_rdata, exp_err});
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        wait_gnt(1'b0, lat);
        check("d_req_to_gnt", 64'(lat), 1);
        d_req = 1'b0; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
        wait_rvalid(1'b0, addr, lat);
        check("d_gnt_to_rvalid", 64'(lat), 64'(exp_lat));
    endtask

    task automatic run_if(input logic [31:0] addr, input int delay, input int exp_lat);
        int lat;
        resp_delay = delay;
        gnt_q.push_back('{1'b1, addr, 1'b0, 32'h0});
        if_rsp_q.push_back('{mem_model(addr), 1'b0});
        if_req = 1'b1; if_addr = addr;
        wait_gnt(1'b1, lat);
        check("if_req_to_gnt", 64'(lat), 1);
        if_req = 1'b0; if_addr = $urandom;
        wait_rvalid(1'b1, addr, lat);
        check("if_gnt_to_rvalid", 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        int lat, n, t;
        bit isf;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // Single load, then rdata must hold while rvalid is low
        run_d(1'b0, 32'h40, 32'hAAAA_0001, 2, 32'h1234, 1'b0, 3);
        repeat (3) begin
            step();
            check("d_rdata_hold", 64'(d_rdata), 64'h1234);
        end

        // Store returns zero rdata
        run_d(1'b1, 32'h44, 32'hDEAD_BEEF, 1, 32'h0, 1'b0, 2);
        // Store timeout: err with rvalid 17 cycles after mem_en
        run_d(1'b1, 32'h80, 32'h0BAD_F00D, 0, 32'h0, 1'b1, 17);
        // Race: mem_ready on the timeout cycle wins
        run_d(1'b0, 32'h84, 32'h1111_2222, 16, mem_model(32'h84), 1'b0, 17);
        // Late mem_ready after a timeout lands in idle and is ignored
        run_d(1'b0, 32'hC0, 32'h3333_4444, 17, 32'h0, 1'b1, 17);
        repeat (3) begin
            step();
            check("late_ready_no_err", 64'(err), 0);
            check("late_ready_no_rvalid", 64'(d_rvalid), 0);
        end

        // Fetch alone
        run_if(32'h100, 1, 2);
        step();

        // Contention with both requests held continuously
        resp_delay = 1;
        for (int i = 0; i < 10; i++) begin
            isf = Fair && (i == 4 || i == 9);
            gnt_q.push_back('{isf, isf ? 32'h1000 : 32'h200, 1'b0, isf ? 32'h0 : 32'h5555});
            if (isf) if_rsp_q.push_back('{mem_model(32'h1000), 1'b0});
            else d_rsp_q.push_back('{mem_model(32'h200), 1'b0});
        end
        if_req = 1'b1; if_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h5555;
        n = 0;
        t = 0;
        while (n < 10 && t < 200) begin
            step();
            t++;
            if (if_gnt || d_gnt) n++;
        end
        check("contention_grants", 64'(n), 10);
        if_req = 1'b0; d_req = 1'b0;
        repeat (6) step();
        check("queues_drained", 64'(gnt_q.size() + if_rsp_q.size() + d_rsp_q.size()), 0);

        // Reset one cycle after if_gnt; the late mem_ready must be ignored
        resp_delay = 4;
        gnt_q.push_back('{1'b1, 32'h300, 1'b0, 32'h0});
        if_req = 1'b1; if_addr = 32'h300;
        wait_gnt(1'b1, lat);
        if_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_all_zero("reset_mid");
        reset = 1'b0;
        repeat (4) begin
            step();
            check("post_reset_no_err", 64'(err), 0);
            check("post_reset_no_if_rvalid", 64'(if_rvalid), 0);
        end
        check_all_zero("post_reset");
        run_if(32'h304, 2, 3);
        repeat (3) step();
        check("final_drained", 64'(gnt_q.size() + if_rsp_q.size() + d_rsp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width.
REQ-002 Parameter: DATA_W, default 32, data width.
REQ-003 Parameter: TIMEOUT, default 16, maximum cycles to wait for mem_ready, range 2..255.
REQ-004 Parameter: STARVE_LIMIT, default 4, consecutive data grants allowed while fetch waits, range 1..15.
REQ-005 Ports, each line giving name, direction, width and meaning:
 clk  in  1  single clock; all logic on rising edge.
 reset  in  1  synchronous, active-high reset.
 if_req  in  1  fetch request; held until if_gnt.
 if_addr  in  ADDR_W  fetch address.
 if_gnt  out  1  one-cycle pulse; fetch accepted.
 if_rvalid  out  1  one-cycle pulse; if_rdata valid.
 if_rdata  out  DATA_W  fetch read data.
 d_req  in  1  data request (LW/SW); held until d_gnt.
 d_we  in  1  1 = store, 0 = load.
 d_addr  in  ADDR_W  data address.
 d_wdata  in  DATA_W  store data.
 d_gnt  out  1  one-cycle pulse; data request accepted.
 d_rvalid  out  1  one-cycle pulse; load data valid, or store done.
 d_rdata  out  DATA_W  load data.
 mem_en  out  1  one-cycle access strobe.
 mem_we  out  1  write enable, valid with mem_en.
 mem_addr  out  ADDR_W  access address, held stable until completion.
 mem_wdata  out  DATA_W  write data, held stable until completion.
 mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
 mem_ready  in  1  one-cycle completion pulse, at least 1 cycle after mem_en.
 err  out  1  one-cycle pulse; access timed out.
REQ-006 All outputs SHALL be registered.

Function
REQ-007 FSM states SHALL be IDLE, BUSY_IF and BUSY_D.
REQ-008 In IDLE, a sampled request SHALL cause the following on the next cycle: the matching gnt pulses, mem_en pulses, mem_addr/mem_we/mem_wdata load from the winner, and the FSM enters the BUSY state of the winner.
REQ-009 Fetch grants SHALL drive mem_we=0 and mem_wdata=0.
REQ-010 Arbitration: when d_req and if_req are both high, data SHALL win, except as REQ-013 states.
REQ-011 In BUSY_*, a sampled mem_ready SHALL cause the following on the next cycle: the owner's rvalid pulses, the owner's rdata takes mem_rdata (stores: d_rdata=0), and the FSM returns to IDLE.
REQ-012 The arbiter SHALL NOT arbitrate in the cycle it returns to IDLE. Minimum grant-to-grant spacing SHALL be 3 cycles.
REQ-013 A 4-bit streak counter SHALL count data grants made while if_req is high. It SHALL clear on any fetch grant and on any arbitration where if_req is low. When the counter equals STARVE_LIMIT and if_req is high, fetch SHALL win.
REQ-014 Requests arriving while in BUSY_* SHALL be held pending, and SHALL NOT be granted until the FSM is in IDLE.
REQ-015 A wait counter SHALL start at mem_en and increment each BUSY cycle. If it reaches TIMEOUT without mem_ready, the following SHALL happen on the next cycle: err pulses, the owner's rvalid pulses with rdata=0, and the FSM returns to IDLE.
REQ-016 If mem_ready and the timeout occur in the same cycle, mem_ready SHALL take precedence, with no err.
REQ-017 A mem_ready sampled in IDLE SHALL be ignored.
REQ-018 rdata outputs SHALL hold their last value when rvalid is low.

Reset
REQ-019 While reset is high, the FSM SHALL go to IDLE and every output, the streak counter and the wait counter SHALL be 0.
REQ-020 If reset is asserted mid-access, the access SHALL be dropped with no rvalid and no err. A late mem_ready after reset SHALL be ignored under REQ-017.

Configuration
REQ-021 Macro MEM_ARBITER_FAIRNESS_EN: when defined, REQ-013 SHALL apply. When undefined, the streak counter SHALL be absent, and data SHALL always win when both requests are present.

Verification
REQ-022 Single load: d_req=1, d_we=0, d_addr=0x40, mem_ready 2 cycles after mem_en with mem_rdata=0x1234 -> d_gnt and mem_en in the same cycle, mem_addr=0x40, then d_rvalid=1 with d_rdata=0x1234 one cycle after mem_ready.
REQ-023 Contention: if_req and d_req held high continuously, fairness enabled, STARVE_LIMIT=4 -> grant order D,D,D,D,IF,D,D,D,D,IF. With the macro undefined -> only D grants.
REQ-024 Timeout: store to 0x80, mem_ready never asserted, TIMEOUT=16 -> err and d_rvalid pulse together 17 cycles after mem_en, then the FSM is in IDLE.
REQ-025 Race: mem_ready arrives in the same cycle the wait counter reaches TIMEOUT -> normal rvalid with mem_rdata, err stays 0.
REQ-026 Reset mid-access: reset asserted 1 cycle after if_gnt, then mem_ready arrives after reset deasserts -> no if_rvalid, no err, all outputs 0, and the next if_req is granted normally.
